// File: rtl/clk_enable_gen.sv
// clk_enable_gen: builds the processor's one-cycle clock-enable strobe from the
// board mode switches and the step button. The switches and the button are
// synchronized first. The button is debounced into one pulse per press. In
// free-run mode, a selectable divider of clk produces periodic strobes instead.
module clk_enable_gen #(
  parameter int CLK_HZ          = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] mode,
  input  logic       step,
  output logic       enable,
  output logic       run
);

  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ + 1) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Period in clk cycles for rate code n: CLK_HZ / 10^(n-1), never below 1.
  function automatic int rate_div(input int code);
    int d;
    d = CLK_HZ;
    for (int i = 1; i < code; i++) d = d / 10;
    if (d < 1) d = 1;
    return d;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  logic [3:0]       mode_meta;
  logic [3:0]       mode_s;
  logic             step_meta;
  logic             step_s;
  logic [DIV_W-1:0] div_last_lut [8];
  logic [2:0]       rate_code;
  logic             mode_change;
  logic             div_active;
  logic             tick;
  logic [DIV_W-1:0] div_cnt_reg;
  db_state_t        state_reg;
  db_state_t        state_next;
  logic [DB_W-1:0]  db_cnt_reg;
  logic [DB_W-1:0]  db_cnt_next;
  logic             step_pulse;
  logic             enable_next;

  // Two-flop synchronizers for the raw switches and the button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_meta <= 4'b0000;
      mode_s    <= 4'b0000;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
    end else begin
      mode_meta <= mode;
      mode_s    <= mode_meta;
      step_meta <= step;
      step_s    <= step_meta;
    end
  end

  assign run       = mode_s[3];
  assign rate_code = mode_s[2:0];

  // Terminal count (period - 1) for each rate code. Entry 0 is never used,
  // because code 0 pauses the divider.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_div_lut
      assign div_last_lut[gi] = DIV_W'(rate_div(gi) - 1);
    end
  endgenerate

  // A change of any switch bit is visible one cycle before it lands in
  // mode_s. Clearing the counter on that cycle gives the new rate a full fresh
  // period. It also swallows a tick that coincides with the switch.
  assign mode_change = (mode_meta != mode_s);
  assign div_active  = run && (rate_code != 3'd0) && !mode_change;
  assign tick        = div_active && (div_cnt_reg == div_last_lut[rate_code]);

  // Free-run divider: counts while active, wraps on tick, otherwise held at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else if (!div_active || tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  // Debounce FSM state and stable-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      db_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      db_cnt_reg <= db_cnt_next;
    end
  end

  // Debounce next-state: accept a level only after it has been stable long
  // enough. Pulse once on an accepted press.
  always_comb begin
    state_next  = state_reg;
    db_cnt_next = db_cnt_reg;
    step_pulse  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (step_s) begin
          state_next  = PRESS_WAIT;
          db_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!step_s) begin
          state_next = IDLE;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next = HELD;
          step_pulse = 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + DB_W'(1);
        end
      end
      HELD: begin
        if (!step_s) begin
          state_next  = RELEASE_WAIT;
          db_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (step_s) begin
          state_next = HELD;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next = IDLE;
        end else begin
          db_cnt_next = db_cnt_reg + DB_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A press is dropped if run is about to rise on the same cycle.
  assign enable_next = (run && tick) || (!run && step_pulse && !mode_meta[3]);

  // Registered strobe output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable <= 1'b0;
    end else begin
      enable <= enable_next;
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Testbench for clk_enable_gen: table-driven scenarios, hand-written corner
// sequences and randomized stimulus, all checked cycle by cycle against a
// behavioural model built from run lengths and period arithmetic.
module tb_clk_enable_gen;
  localparam int CLK_HZ = 1000;
  localparam int DB     = 8;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic [3:0] mode_in = 4'b0000;
  logic       step_in = 1'b0;
  logic       enable;
  logic       run;

  clk_enable_gen #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode_in),
    .step  (step_in),
    .enable(enable),
    .run   (run)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // clock edges since the last reset release
  int pulse_cnt, first_pulse, last_pulse, min_gap, max_gap;

  // Reference model state: input history, press/release run lengths, and
  // the edge at which the free-run period last restarted.
  logic [3:0] h_mode1, h_mode2;
  logic       h_step1, h_step2;
  int         one_run, zero_run, last_clear;
  bit         accepted, exp_enable;

  typedef struct {
    logic [8*12-1:0] name;
    logic [3:0]      mode;
    int              kind;      // 0: step low, 1: held 20 cycles, 2: bouncy
    int              ncyc;
    int              exp_count;
    int              exp_first;
    int              exp_gap;   // 0: spacing not checked
  } vec_t;

  vec_t vecs [8];

  function automatic int rate_div(input int code);
    int p;
    p = 1;
    repeat (code - 1) p = p * 10;
    return (CLK_HZ / p < 1) ? 1 : CLK_HZ / p;
  endfunction

  function automatic logic step_at(input int kind, input int j);
    if (kind == 1) return (j <= 20);
    if (kind == 2) return (j > 30) ? 1'b1 : (((j - 1) / 3) % 2 == 0);
    return 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    pulse_cnt   = 0;
    first_pulse = -1;
    last_pulse  = -1;
    min_gap     = 1 << 30;
    max_gap     = 0;
  endtask

  task automatic model_reset();
    h_mode1 = 4'b0000; h_mode2 = 4'b0000;
    h_step1 = 1'b0;    h_step2 = 1'b0;
    one_run = 0; zero_run = 0; last_clear = 0; accepted = 1'b0;
    cyc = 0;
    clear_stats();
  endtask

  // Advance the model by one edge, using the inputs the DUT sampled there.
  task automatic model_edge();
    bit pulse, run_c, chg, f_strobe, s_strobe;
    int code;
    cyc++;
    run_c = h_mode2[3];
    code  = int'(h_mode2[2:0]);
    chg   = (h_mode1 != h_mode2);
    if (h_step2) begin one_run++; zero_run = 0; end
    else begin zero_run++; one_run = 0; end
    pulse = 1'b0;
    if (!accepted && one_run == DB + 1) begin
      pulse = 1'b1;
      accepted = 1'b1;
    end else if (accepted && zero_run == DB + 1) begin
      accepted = 1'b0;
    end
    f_strobe = 1'b0;
    if (chg || !run_c || code == 0) last_clear = cyc;
    else if ((cyc - last_clear) % rate_div(code) == 0) f_strobe = 1'b1;
    s_strobe   = pulse && !run_c && !h_mode1[3];
    exp_enable = f_strobe || s_strobe;
    h_mode2 = h_mode1; h_mode1 = mode_in;
    h_step2 = h_step1; h_step1 = step_in;
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("enable", int'(enable), int'(exp_enable));
    check("run", int'(run), int'(h_mode2[3]));
    if (enable) begin
      if (last_pulse >= 0) begin
        if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
        if (cyc - last_pulse > max_gap) max_gap = cyc - last_pulse;
      end
      if (first_pulse < 0) first_pulse = cyc;
      last_pulse = cyc;
      pulse_cnt++;
    end
  endtask

  task automatic run_to(input int last);
    while (cyc < last) tick_cycle();
  endtask

  // Assert reset between edges, confirm outputs drop at once, hold it for two
  // edges and release just after an edge so the next edge is edge 1.
  task automatic do_reset(input logic [3:0] m, input logic s);
    rst_n   = 1'b0;
    mode_in = m;
    step_in = s;
    #1;
    check("reset_enable_now", int'(enable), 0);
    check("reset_run_now", int'(run), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_enable_held", int'(enable), 0);
    check("reset_run_held", int'(run), 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"clean_step",   4'b0000, 1,   60,  1,  11,   0};
    vecs[1] = '{"bounce",       4'b0000, 2,   70,  1,  41,   0};
    vecs[2] = '{"run_div10",    4'b1011, 0,  102, 10,  12,  10};
    vecs[3] = '{"run_div1",     4'b1100, 0,   50, 48,   3,   1};
    vecs[4] = '{"clamp_code7",  4'b1111, 0,   50, 48,   3,   1};
    vecs[5] = '{"paused",       4'b1000, 0, 2000,  0,  -1,   0};
    vecs[6] = '{"run_div100",   4'b1010, 0,  250,  2, 102, 100};
    vecs[7] = '{"run_ign_step", 4'b1000, 1,   60,  0,  -1,   0};

    #2;
    do_reset(4'b0000, 1'b0);

    // Table-driven scenarios, each from a fresh reset.
    for (int i = 0; i < 8; i++) begin
      do_reset(vecs[i].mode, step_at(vecs[i].kind, 1));
      for (int j = 1; j <= vecs[i].ncyc; j++) begin
        mode_in = vecs[i].mode;
        step_in = step_at(vecs[i].kind, j);
        tick_cycle();
      end
      check("vec_count", pulse_cnt, vecs[i].exp_count);
      check("vec_first", first_pulse, vecs[i].exp_first);
      if (vecs[i].exp_gap > 0) begin
        check("vec_min_gap", min_gap, vecs[i].exp_gap);
        check("vec_max_gap", max_gap, vecs[i].exp_gap);
      end
      $display("vec %0d %s: pulses=%0d first=%0d", i, vecs[i].name, pulse_cnt, first_pulse);
    end

    // Rate change mid-period: old boundary at 52 is dropped, the new period starts fresh.
    do_reset(4'b1011, 1'b0);
    run_to(45);
    check("rate_pre_count", pulse_cnt, 4);
    mode_in = 4'b1010;
    clear_stats();
    run_to(150);
    check("rate_post_count", pulse_cnt, 1);
    check("rate_post_first", first_pulse, 147);
    $display("seq rate_change: pulses=%0d first=%0d", pulse_cnt, first_pulse);

    // Run to step in the same cycle as a tick: the tick due at 52 must not appear.
    do_reset(4'b1011, 1'b0);
    run_to(50);
    mode_in = 4'b0011;
    clear_stats();
    run_to(80);
    check("run_to_step_count", pulse_cnt, 0);
    $display("seq run_to_step: pulses=%0d", pulse_cnt);

    // Step to run in the same cycle as an accepted press: the press is discarded.
    do_reset(4'b0000, 1'b1);
    run_to(9);
    mode_in = 4'b1000;
    run_to(60);
    check("step_to_run_count", pulse_cnt, 0);
    check("step_to_run_run", int'(run), 1);
    $display("seq step_to_run: pulses=%0d", pulse_cnt);

    // Reset during a free-run strobe, then reset mid-debounce with the button held.
    do_reset(4'b1011, 1'b0);
    run_to(12);
    check("strobe_before_reset", int'(enable), 1);
    do_reset(4'b0000, 1'b1);
    run_to(5);
    do_reset(4'b0000, 1'b1);
    run_to(40);
    check("reset_mid_db_count", pulse_cnt, 1);
    check("reset_mid_db_first", first_pulse, 11);
    $display("seq reset_mid_debounce: pulses=%0d first=%0d", pulse_cnt, first_pulse);

    // Randomized switches and button activity against the model.
    for (int seg = 0; seg < 8; seg++) begin
      int hold;
      do_reset(4'($urandom), 1'($urandom));
      hold = $urandom_range(1, 24);
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 39) == 0) mode_in = 4'($urandom);
        if (hold == 0) begin
          step_in = ~step_in;
          hold = $urandom_range(1, 24);
        end else begin
          hold--;
        end
        tick_cycle();
      end
      $display("random segment %0d: strobes=%0d", seg, pulse_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Generates the single-cycle processor clock-enable strobe from the board controls. It sits directly upstream of the processor's `clk_en` input, in the `MCLK` domain. It synchronizes the mode switches and the raw step button, and debounces the button into exactly one pulse per press. It also divides the main clock into seven selectable free-run rates.

## Interface
- `CLK_HZ`, 10_000_000, frequency of `clk` in Hz; base for the rate divisors.
- `DEBOUNCE_CYCLES`, 100_000, consecutive stable cycles required to accept a button edge (10 ms at 10 MHz).
- `clk`  in  1  main clock (`MCLK`); sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  4  raw switches: `mode[3]` = 1 selects free-run, 0 selects single step; `mode[2:0]` is the rate code.
- `step`  in  1  raw, bouncy step button, active high.
- `enable`  out  1  one-`clk`-wide processor clock-enable strobe.
- `run`  out  1  synchronized `mode[3]`, for status display.

## Operation
- **Synchronizers**
  - `mode` and `step` each pass through a 2-flop synchronizer.
  - All logic below uses only the synchronized copies (`mode_s`, `step_s`).
- **Debounce FSM** (always active, in both modes). States:
  - `IDLE`: `step_s`=1 → `PRESS_WAIT`, counter cleared.
  - `PRESS_WAIT`: counter increments while `step_s`=1. `step_s`=0 → `IDLE`. Counter reaches `DEBOUNCE_CYCLES`-1 with `step_s`=1 → `HELD`, and `step_pulse` is asserted for that one transition cycle.
  - `HELD`: `step_s`=0 → `RELEASE_WAIT`, counter cleared.
  - `RELEASE_WAIT`: counter increments while `step_s`=0. `step_s`=1 → `HELD`. Counter reaches `DEBOUNCE_CYCLES`-1 → `IDLE`.
  - Result: exactly one pulse per accepted press. Holding the button produces no repeat.
- **Rate divisor**
  - Code n in 1..7 gives `div(n) = max(1, CLK_HZ / 10^(n-1))`. At 10 MHz: 10_000_000, 1_000_000, 100_000, 10_000, 1_000, 100, 10.
  - Code 0 means paused: no free-run strobes.
- **Divider counter**
  - Width ≥ clog2(`CLK_HZ`).
  - Increments every cycle while `run`=1 and the code is nonzero.
  - At `div`-1 it raises `tick` and wraps to 0. `div`=1 gives `tick` every cycle.
  - Cleared to 0 when `mode_s` changes value (any bit) and while `run`=0. A new rate always starts a full fresh period.
- **Output**
  - `enable` = registered (`run` & `tick`) | (!`run` & `step_pulse`).
  - Step presses are ignored in free-run. Divider ticks never leak into step mode.

## Timing
- **Reset:** `enable`=0, `run`=0, FSM=`IDLE`, all counters and synchronizers 0.
- `enable` is a registered output and is never high two consecutive cycles unless `div`=1.
- **Mode latency:** a switch change reaches `run` and the divider after 2 `clk` edges.
- **Step latency:** `enable` rises 2 (sync) + `DEBOUNCE_CYCLES` + 1 (output register) cycles after the button's clean rising edge.
- **Free-run period:** the first strobe comes `div` cycles after the counter clears, then one strobe every `div` cycles exactly.
- **Run→step in the same cycle as a tick:** the new `run`=0 wins and no strobe is issued.
- **Step→run with an accepted press in the same cycle:** `run`=1 wins and the press is discarded.
- **Reset mid-debounce or mid-period:** all state is dropped immediately. After release, a button still held must pass a full debounce before it can pulse.
- **Reset release:** `rst_n` deassertion is synchronized externally by the top level. The block does not re-synchronize it.

## Test plan
All scenarios use `CLK_HZ`=1000 and `DEBOUNCE_CYCLES`=8.
- **Clean step:** `mode`=0, `step` high for 20 cycles → exactly one `enable` pulse, 11 cycles after the rise; none on release.
- **Bounce rejection:** `mode`=0, `step` toggles every 3 cycles for 30 cycles, then stays high → one pulse only, 11 cycles after the final rise.
- **Free-run rate:** `mode`=4'b1011 (div 10) for 100 cycles → exactly 10 pulses spaced 10 apart. `mode`=4'b1100 (div 1) → `enable` high every cycle.
- **Clamp and pause:** `mode`=4'b1111 → pulse every cycle (div clamped to 1). `mode`=4'b1000 → no pulses over 2000 cycles.
- **Rate change:** switch 4'b1011 → 4'b1010 mid-period → no strobe at the old boundary. The next strobe comes 102 cycles after the switch edge (2 sync + 100).
- **Reset mid-operation:** assert `rst_n`=0 at cycle 5 of a debounce while holding `step` → `enable`=0 and `run`=0 immediately. After release with `step` still held, one pulse occurs 11 cycles later.
